// File: rtl/radar_pkg.sv
// Shared definitions for the distance display path: FSM encoding, digit count
// and 7-segment codes (active high, bit6=a .. bit0=g).
// Latency: n/a (package). Backpressure: n/a.
package radar_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 11;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } disp_state_t;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Non-decimal nibbles cannot come out of the converter; show them blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 11-bit binary to four BCD nibbles, one bit per clk.
// Latency: start sampled at edge N, iterations on edges N+1..N+11, bcd valid after N+11.
// Backpressure: none; start is ignored while a conversion runs.
// Ports: clk, rst_n (async active-low), start/bin (request), done (final
// iteration happens on the coming edge), bcd (result, thousands in [15:12]).
module bin2bcd_seq
  import radar_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       iter_q;
  logic             run_q;
  logic [BCD_W-1:0] bcd_adj;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
    end else if (run_q) begin
      bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
      if (iter_q == LAST_ITER) begin
        iter_q <= '0;
        run_q  <= 1'b0;
      end else begin
        iter_q <= iter_q + 4'd1;
      end
    end else if (start) begin
      bin_q  <= bin;
      bcd_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b1;
    end
  end

  assign done = run_q && (iter_q == LAST_ITER);
  assign bcd  = bcd_q;

endmodule

// File: rtl/dist_disp_mux.sv
// Distance-to-display: converts an 11-bit cm reading to BCD and scans 4 digits.
// Latency: digits update on the 12th edge after the dist_valid edge.
// Backpressure: none; dist_valid outside IDLE is dropped, busy flags the window.
// Ports: clk, rst_n (async active-low), dist_cm/dist_valid (reading),
// seg_out (a..g active high), dig_en (one-hot, bit0 = units), busy.
module dist_disp_mux
  import radar_pkg::*;
#(
  parameter int SCAN_DIV = 27000,
  parameter int BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] dist_cm,
  input  logic             dist_valid,
  output logic [6:0]       seg_out,
  output logic [3:0]       dig_en,
  output logic             busy
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

  disp_state_t                    state;
  logic                           conv_start;
  logic                           conv_done;
  logic [BCD_W-1:0]               conv_bcd;
  logic [NUM_DIGITS-1:0][3:0]     digits_q;
  logic [SCW-1:0]                 scan_cnt;
  logic [1:0]                     dig_idx;
  logic [NUM_DIGITS-1:0]          lead_zero;
  logic                           all_zero_above;
  logic                           blank;

  assign conv_start = (state == IDLE) && dist_valid;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (dist_cm),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // busy trails the state by one edge: it rises on the edge after capture and
  // covers the LOAD cycle before dropping once the FSM has settled in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      digits_q <= '0;
    end else begin
      busy <= (state != IDLE);
      case (state)
        IDLE: if (dist_valid) state <= CONV;
        CONV: if (conv_done) state <= LOAD;
        LOAD: begin
          digits_q <= conv_bcd;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running scan; display updates never touch its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCW'(1);
    end
  end

  // lead_zero[i] is set when digit i and every digit above it are zero.
  always_comb begin
    dig_en          = '0;
    dig_en[dig_idx] = 1'b1;
    lead_zero       = '0;
    all_zero_above  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero_above = all_zero_above && (digits_q[i] == 4'd0);
      lead_zero[i]   = all_zero_above;
    end
    blank   = (BLANK_LZ != 0) && (dig_idx != 2'd0) && lead_zero[dig_idx];
    seg_out = blank ? SEG_BLANK : seg_encode(digits_q[dig_idx]);
  end

endmodule
